// File: rtl/led_chaser_pkg.sv
// rtl/led_chaser_pkg.sv - shared types and constants for the LED chaser
package led_chaser_pkg;

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'd0,
        MODE_ROTR   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam int NUM_MODES = 4;

    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(2'((int'(m) + 1) % NUM_MODES));
    endfunction

endpackage

// File: rtl/led_chaser_btn_conditioner.sv
// rtl/led_chaser_btn_conditioner.sv - button synchroniser, debounce and rise pulse
module btn_conditioner #(
    parameter int unsigned DEBOUNCE    = 16'd50000,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Synchroniser resets to the released level so no spurious edge follows reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= RESET_LEVEL;
            sync2 <= RESET_LEVEL;
            level <= RESET_LEVEL;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    rise  <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/led_chaser.sv
// rtl/led_chaser.sv - rotating/bouncing/fill LED pattern generator with debounced buttons
module led_chaser
    import led_chaser_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int          DIV_W    = 24,
    parameter int unsigned DEBOUNCE = 16'd50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_n,
    input  logic             mode_btn,
    input  logic [DIV_W-1:0] step_div,
    output logic [WIDTH-1:0] lights,
    output logic [1:0]       mode
);

    logic             run_n_level;
    logic             run_rise_unused;
    logic             btn_level_unused;
    logic             press;
    logic             run;
    logic             tick;
    logic [DIV_W-1:0] count;
    mode_t            mode_q;
    dir_t             dir;
    dir_t             dir_next;
    logic [WIDTH-1:0] pat;
    logic [WIDTH-1:0] pat_next;

    btn_conditioner #(
        .DEBOUNCE    (DEBOUNCE),
        .RESET_LEVEL (1'b1)
    ) u_run_btn (
        .clk   (clk),
        .reset (reset),
        .raw   (run_n),
        .level (run_n_level),
        .rise  (run_rise_unused)
    );

    btn_conditioner #(
        .DEBOUNCE    (DEBOUNCE),
        .RESET_LEVEL (1'b0)
    ) u_mode_btn (
        .clk   (clk),
        .reset (reset),
        .raw   (mode_btn),
        .level (btn_level_unused),
        .rise  (press)
    );

    assign run  = ~run_n_level;
    assign tick = run && (count == step_div);

    always_comb begin
        pat_next = pat;
        dir_next = dir;
        unique case (mode_q)
            MODE_ROTL: pat_next = {pat[WIDTH-2:0], pat[WIDTH-1]};
            MODE_ROTR: pat_next = {pat[0], pat[WIDTH-1:1]};
            MODE_BOUNCE: begin
                // Direction flips on reaching an end so the end value is not repeated.
                if (dir == DIR_LEFT) begin
                    pat_next = pat << 1;
                    if (pat_next[WIDTH-1]) dir_next = DIR_RIGHT;
                end else begin
                    pat_next = pat >> 1;
                    if (pat_next[0]) dir_next = DIR_LEFT;
                end
            end
            MODE_FILL: begin
                if (&pat) pat_next = WIDTH'(1);
                else      pat_next = (pat << 1) | WIDTH'(1);
            end
            default: pat_next = pat;
        endcase
    end

    // A mode press overrides a coincident tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_ROTL;
            dir    <= DIR_LEFT;
            pat    <= WIDTH'(1);
            count  <= '0;
        end else if (press) begin
            mode_q <= next_mode(mode_q);
            dir    <= DIR_LEFT;
            pat    <= WIDTH'(1);
            count  <= '0;
        end else if (!run) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
            pat   <= pat_next;
            dir   <= dir_next;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign lights = pat;
    assign mode   = mode_q;

endmodule

// File: tb/tb_led_chaser.sv
// tb/tb_led_chaser.sv - randomized self-checking bench for led_chaser
module tb_led_chaser;

    localparam int W     = 8;
    localparam int DW    = 8;
    localparam int DEB   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          run_n = 1'b0;
    logic          mode_btn = 1'b0;
    logic [DW-1:0] step_div = '0;
    logic [W-1:0]  lights;
    logic [1:0]    mode;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    led_chaser #(.WIDTH(W), .DIV_W(DW), .DEBOUNCE(DEB)) dut (
        .clk      (clk),
        .reset    (reset),
        .run_n    (run_n),
        .mode_btn (mode_btn),
        .step_div (step_div),
        .lights   (lights),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference: pattern is a pure function of mode and number of steps since the last mode change.
    function automatic logic [W-1:0] exp_lights(input int md, input int st);
        logic [W-1:0] one;
        int k;
        one = 1;
        case (md)
            0: return one << (st % W);
            1: return one << ((W - st % W) % W);
            2: begin
                k = st % (2 * W - 2);
                return one << ((k < W) ? k : (2 * W - 2 - k));
            end
            default: return W'((1 << (st % W + 1)) - 1);
        endcase
    endfunction

    function automatic bit window_all(input bit q[$], input bit v);
        for (int i = 1; i <= DEB; i++)
            if (q[i] != v) return 0;
        return 1;
    endfunction

    int m_mode, m_step, m_cnt;
    bit m_run_lvl, m_btn_lvl, m_press;
    bit rq_run[$];
    bit rq_btn[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_step = 0; m_cnt = 0;
            m_run_lvl = 1; m_btn_lvl = 0; m_press = 0;
            rq_run = {}; rq_btn = {};
            for (int i = 0; i < DEB + 2; i++) begin
                rq_run.push_back(1'b1);
                rq_btn.push_back(1'b0);
            end
        end else begin
            if (m_press) begin
                m_mode = (m_mode + 1) % 4; m_step = 0; m_cnt = 0;
            end else if (m_run_lvl) begin
                m_cnt = 0;
            end else if (m_cnt == int'(step_div)) begin
                m_step++; m_cnt = 0;
            end else begin
                m_cnt = (m_cnt + 1) % (1 << DW);
            end
            rq_run.push_back(run_n);
            rq_btn.push_back(mode_btn);
            m_press = 0;
            if (window_all(rq_run, !m_run_lvl)) m_run_lvl = !m_run_lvl;
            if (window_all(rq_btn, !m_btn_lvl)) begin
                m_btn_lvl = !m_btn_lvl;
                m_press = m_btn_lvl;
            end
            void'(rq_run.pop_front());
            void'(rq_btn.pop_front());
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("lights", 32'(lights), 32'(exp_lights(m_mode, m_step)));
            check("mode", 32'(mode), 32'(m_mode));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn();
        mode_btn = 1'b1; cycles(DEB + 4);
        mode_btn = 1'b0; cycles(DEB + 4);
    endtask

    initial begin
        int presses;
        #1 reset = 1'b1;
        cycles(3);
        check("rst_lights", 32'(lights), 32'h1);
        check("rst_mode", 32'(mode), 32'h0);
        reset = 1'b0;
        checking = 1;
        cycles(30);

        step_div = 3; run_n = 1'b1; cycles(10);
        press_btn();
        run_n = 1'b0; cycles(40);

        step_div = 0; press_btn(); cycles(40);
        press_btn(); cycles(30);

        for (int i = 0; i < 7; i++) begin
            mode_btn = (i % 2 == 0) && (i != 6);
            cycles(2);
        end
        mode_btn = 1'b0; cycles(10);
        check("glitch_mode", 32'(mode), 32'h3);

        step_div = 5; cycles(3);
        run_n = 1'b1; cycles(20);
        run_n = 1'b0; cycles(20);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: begin
                    mode_btn = 1'b1; cycles($urandom_range(DEB + 2, DEB + 5));
                    mode_btn = 1'b0; cycles($urandom_range(DEB + 2, DEB + 5));
                end
                1: run_n = ~run_n;
                2: begin
                    mode_btn = 1'b1; cycles($urandom_range(1, DEB - 1));
                    mode_btn = 1'b0;
                end
                3: step_div = DW'($urandom_range(0, 6));
                default: begin
                    run_n = ~run_n; cycles($urandom_range(1, DEB - 1));
                    run_n = ~run_n;
                end
            endcase
            cycles($urandom_range(3, 25));
        end

        step_div = 0; run_n = 1'b0;
        presses = (2 - m_mode + 4) % 4;
        for (int i = 0; i < presses; i++) press_btn();
        cycles(13);
        check("bounce_mode", 32'(mode), 32'h2);
        #2 reset = 1'b1;
        #1;
        check("async_lights", 32'(lights), 32'h1);
        check("async_mode", 32'(mode), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cycles(20);

        checking = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
